// File: rtl/snitch_perf_counters.sv
// Cluster performance counters: staged per-core event strobes feed NrCounters
// programmable counters behind a word-addressed register port.
// Optional global FREEZE register at 0xFC when SNITCH_PERF_FREEZE_EN is defined.
module snitch_perf_counters #(
  parameter int unsigned NrCores      = 8,
  parameter int unsigned NrCounters   = 4,
  parameter int unsigned CounterWidth = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NrCores*7-1:0] core_events_i,
  input  logic                 reg_req_i,
  input  logic                 reg_we_i,
  input  logic [7:0]           reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic                 reg_gnt_o,
  output logic                 reg_rvalid_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_err_o,
  output logic                 overflow_irq_o
);
  localparam int unsigned EvtW    = NrCores * 7;
  localparam int unsigned EvtIdxW = $clog2(EvtW);
  localparam int unsigned HiW     = CounterWidth - 32;

  logic [EvtW-1:0]         evt_q;
  logic [CounterWidth-1:0] cnt_q  [NrCounters];
  logic [CounterWidth-1:0] cnt_d  [NrCounters];
  logic [2:0]              sel_q  [NrCounters];
  logic [2:0]              sel_d  [NrCounters];
  logic [7:0]              core_q [NrCounters];
  logic [7:0]              core_d [NrCounters];
  logic [NrCounters-1:0]   en_q, en_d, ovf_q, ovf_d, inc, val_wr;
  logic                    rvalid_q, err_q, err_d, irq_q;
  logic [31:0]             rdata_q, rdata_d;
  logic                    wr, mapped, halt;
`ifdef SNITCH_PERF_FREEZE_EN
  logic                    freeze_q, freeze_d;
`endif

  assign reg_gnt_o      = reg_req_i;
  assign reg_rvalid_o   = rvalid_q;
  assign reg_rdata_o    = rdata_q;
  assign reg_err_o      = err_q;
  assign overflow_irq_o = irq_q;

  // Register writes, counter increments and read-data mux; config and freeze
  // writes already govern counting on their own write edge.
  always_comb begin
    en_d    = en_q;
    ovf_d   = ovf_q;
    sel_d   = sel_q;
    core_d  = core_q;
    cnt_d   = cnt_q;
    inc     = '0;
    val_wr  = '0;
    rdata_d = '0;
    wr      = reg_req_i & reg_we_i;
    mapped  = 32'(reg_addr_i[7:2]) < NrCounters;
    halt    = 1'b0;
`ifdef SNITCH_PERF_FREEZE_EN
    freeze_d = freeze_q;
    if (reg_addr_i == 8'hFC) begin
      mapped = 1'b1;
      if (wr) freeze_d = reg_wdata_i[0];
      rdata_d = {31'b0, freeze_q};
    end
    halt = freeze_d;
`endif
    for (int unsigned i = 0; i < NrCounters; i++) begin
      if (reg_addr_i[7:2] == 6'(i)) begin
        case (reg_addr_i[1:0])
          2'd0: begin
            rdata_d = {16'h0, core_q[i], 4'h0, sel_q[i], en_q[i]};
            if (wr) begin
              en_d[i]   = reg_wdata_i[0];
              sel_d[i]  = reg_wdata_i[3:1];
              core_d[i] = reg_wdata_i[15:8];
            end
          end
          2'd1: begin
            rdata_d = cnt_q[i][31:0];
            if (wr) begin
              cnt_d[i][31:0] = reg_wdata_i;
              val_wr[i]      = 1'b1;
            end
          end
          2'd2: begin
            rdata_d = 32'(cnt_q[i][CounterWidth-1:32]);
            if (wr) begin
              cnt_d[i][CounterWidth-1:32] = reg_wdata_i[HiW-1:0];
              val_wr[i]                   = 1'b1;
            end
          end
          default: begin
            rdata_d = {31'b0, ovf_q[i]};
            if (wr && reg_wdata_i[0]) ovf_d[i] = 1'b0;
          end
        endcase
      end
      inc[i] = en_d[i] && !halt &&
               (sel_d[i] == 3'd7 ||
                (32'(core_d[i]) < NrCores &&
                 evt_q[EvtIdxW'(32'(core_d[i]) * 32'd7 + 32'(sel_d[i]))]));
      // A value write owns the edge; overflow set overrides a same-edge W1C.
      if (inc[i] && !val_wr[i]) begin
        cnt_d[i] = cnt_q[i] + CounterWidth'(1);
        if (&cnt_q[i]) ovf_d[i] = 1'b1;
      end
    end
    err_d = reg_req_i & ~mapped;
    if (!reg_req_i || reg_we_i || !mapped) rdata_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      evt_q    <= '0;
      en_q     <= '0;
      ovf_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      for (int unsigned i = 0; i < NrCounters; i++) begin
        cnt_q[i]  <= '0;
        sel_q[i]  <= '0;
        core_q[i] <= '0;
      end
`ifdef SNITCH_PERF_FREEZE_EN
      freeze_q <= 1'b0;
`endif
    end else begin
      evt_q    <= core_events_i;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      core_q   <= core_d;
      rvalid_q <= reg_req_i;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      irq_q    <= |ovf_d;
`ifdef SNITCH_PERF_FREEZE_EN
      freeze_q <= freeze_d;
`endif
    end
  end
endmodule

// File: tb/tb_snitch_perf_counters.sv
// Bench for snitch_perf_counters: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the counter unit.
module tb_snitch_perf_counters;
  localparam int unsigned NC = 8;
  localparam int unsigned NK = 4;
  localparam int unsigned CW = 48;
  localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC*7-1:0] events;
  logic            req, we;
  logic [7:0]      addr;
  logic [31:0]     wdata;
  logic            gnt, rvalid, err, irq;
  logic [31:0]     rdata;

  always #5 clk = ~clk;

  snitch_perf_counters #(.NrCores(NC), .NrCounters(NK), .CounterWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .core_events_i(events),
    .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_gnt_o(gnt), .reg_rvalid_o(rvalid), .reg_rdata_o(rdata),
    .reg_err_o(err), .overflow_irq_o(irq)
  );

  // Reference state: plain integers per counter
  logic [63:0]     m_cnt  [NK];
  logic            m_en   [NK];
  logic [2:0]      m_sel  [NK];
  logic [7:0]      m_core [NK];
  logic            m_ovf  [NK];
  logic            m_frz;
  logic [NC*7-1:0] m_evt;
  int n_checks = 0;
  int n_err    = 0;

  localparam bit HAS_FREEZE =
`ifdef SNITCH_PERF_FREEZE_EN
    1'b1;
`else
    1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Predict the response and the next model state, advance one edge, compare.
  task automatic step();
    logic        e_rv, e_err, e_irq, is_mapped, frz_n, valw;
    logic [31:0] e_rd;
    int          idx, r, bi;
    chk("gnt", gnt, req);
    idx = int'(addr) / 4;
    r   = int'(addr) % 4;
    is_mapped = (int'(addr) < 4 * NK) || (HAS_FREEZE && addr == 8'hFC);
    e_rv = rst_n & req;
    e_err = 1'b0;
    e_rd = '0;
    if (rst_n && req) begin
      e_err = !is_mapped;
      if (is_mapped && !we) begin
        if (addr == 8'hFC) e_rd = {31'b0, m_frz};
        else case (r)
          0: e_rd = {16'h0, m_core[idx], 4'h0, m_sel[idx], m_en[idx]};
          1: e_rd = m_cnt[idx][31:0];
          2: e_rd = m_cnt[idx][63:32];
          default: e_rd = {31'b0, m_ovf[idx]};
        endcase
      end
    end
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) begin
        m_cnt[k] = '0; m_en[k] = 1'b0; m_sel[k] = '0; m_core[k] = '0; m_ovf[k] = 1'b0;
      end
      m_frz = 1'b0;
      m_evt = '0;
    end else begin
      frz_n = m_frz;
      if (HAS_FREEZE && req && we && addr == 8'hFC) frz_n = wdata[0];
      for (int k = 0; k < NK; k++) begin
        valw = 1'b0;
        if (req && we && idx == k) begin
          case (r)
            0: begin m_en[k] = wdata[0]; m_sel[k] = wdata[3:1]; m_core[k] = wdata[15:8]; end
            1: begin m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | 64'(wdata); valw = 1'b1; end
            2: begin m_cnt[k] = (m_cnt[k] & 64'hFFFF_FFFF) | ((64'(wdata) << 32) & CMASK); valw = 1'b1; end
            default: if (wdata[0]) m_ovf[k] = 1'b0;
          endcase
        end
        bi = int'(m_core[k]) * 7 + int'(m_sel[k]);
        if (m_en[k] && !frz_n && !valw &&
            (m_sel[k] == 3'd7 || (int'(m_core[k]) < NC && m_evt[bi]))) begin
          m_cnt[k] = (m_cnt[k] + 64'd1) & CMASK;
          if (m_cnt[k] == 64'd0) m_ovf[k] = 1'b1;
        end
      end
      m_frz = frz_n;
      m_evt = events;
    end
    e_irq = 1'b0;
    for (int k = 0; k < NK; k++) e_irq |= m_ovf[k];
    @(posedge clk);
    #1;
    chk("rvalid", rvalid, e_rv);
    chk("rdata", rdata, e_rd);
    chk("err", err, e_err);
    chk("irq", irq, e_irq);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] lit, input logic lit_err);
    req = 1'b1; we = 1'b0; addr = a; wdata = '0;
    step();
    req = 1'b0;
    chk("lit_rdata", rdata, lit);
    chk("lit_err", err, lit_err);
  endtask

  initial begin
    logic [63:0] ev;
    int          k;
    rst_n = 1'b0; events = '0; req = 1'b1; we = 1'b0; addr = 8'd1; wdata = '0;
    repeat (3) step();
    chk("lit_rst_rvalid", rvalid, 1'b0);
    rst_n = 1'b1;
    req = 1'b0;

    rd(8'd0, 32'd0, 1'b0);
    rd(8'd1, 32'd0, 1'b0);
    chk("lit_rst_irq", irq, 1'b0);

    // Only core 2's retired_instr strobes are counted
    wr(8'd0, 32'h0000_0207);
    events = '0; events[2*7+3] = 1'b1;
    repeat (5) step();
    events = '0; events[1*7+3] = 1'b1;
    repeat (5) step();
    events = '0;
    idle(2);
    rd(8'd1, 32'd5, 1'b0);
    rd(8'd0, 32'h0000_0207, 1'b0);

    // Wrap through all-ones on cycle counting
    wr(8'd2, 32'h0000_FFFF);
    wr(8'd1, 32'hFFFF_FFFE);
    wr(8'd0, 32'h0000_000F);
    idle(2);
    wr(8'd0, 32'h0000_000E);
    rd(8'd1, 32'd1, 1'b0);
    rd(8'd2, 32'd0, 1'b0);
    rd(8'd3, 32'd1, 1'b0);
    chk("lit_irq_set", irq, 1'b1);
    wr(8'd3, 32'd1);
    chk("lit_irq_clr", irq, 1'b0);
    rd(8'd3, 32'd0, 1'b0);

    // Value write collides with an increment
    wr(8'd4, 32'h0000_000F);
    idle(3);
    wr(8'd5, 32'h0000_0100);
    rd(8'd5, 32'h0000_0100, 1'b0);
    rd(8'd5, 32'h0000_0101, 1'b0);
    wr(8'd4, 32'h0000_000E);

    // Unmapped address
    rd(8'h40, 32'd0, 1'b1);
    wr(8'h40, 32'hFFFF_FFFF);
    chk("lit_wr_err", err, 1'b1);
    rd(8'd1, 32'd1, 1'b0);
    rd(8'd5, 32'h0000_0102, 1'b0);

`ifdef SNITCH_PERF_FREEZE_EN
    wr(8'hFC, 32'd1);
    wr(8'd4, 32'h0000_000F);
    idle(10);
    rd(8'd5, 32'h0000_0102, 1'b0);
    rd(8'hFC, 32'd1, 1'b0);
    wr(8'hFC, 32'd0);
    rd(8'd5, 32'h0000_0103, 1'b0);
    wr(8'd4, 32'h0000_000E);
`else
    rd(8'hFC, 32'd0, 1'b1);
`endif

    // Randomized traffic against the model
    repeat (3000) begin
      ev = {$urandom, $urandom};
      events = ev[NC*7-1:0];
      req = ($urandom_range(0, 9) < 7);
      we  = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, NK + 1);
      if (k < NK) addr = 8'(k * 4 + $urandom_range(0, 3));
      else if (k == NK) addr = ($urandom_range(0, 1) == 1) ? 8'hFC : 8'h40;
      else addr = 8'($urandom);
      wdata = $urandom;
      if (int'(addr) < 4 * NK) begin
        if (addr[1:0] == 2'd0) wdata[15:8] = 8'($urandom_range(0, NC + 1));
        if (addr[1:0] == 2'd1 && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if (addr[1:0] == 2'd2 && $urandom_range(0, 1) == 1) wdata = 32'h0000_FFFF;
      end
      step();
    end

    events = '0;
    for (int a = 0; a < 4 * NK; a++) begin
      req = 1'b1; we = 1'b0; addr = 8'(a); wdata = '0;
      step();
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/snitch_perf_counters.md
Name: snitch_perf_counters

Overview:
- Cluster-peripheral performance counter unit, directly downstream of the per-core event strobes (core_events_t) emitted by every Snitch core.
- Registers the strobes, then counts the selected events in NrCounters programmable counters.
- Counters are exposed through a simple word-addressed request/response register port.
- Raises a level interrupt when any counter wraps.

Parameters:
- NrCores, 8, number of cores whose core_events_t vectors are input (1..256).
- NrCounters, 4, number of programmable counters (1..63).
- CounterWidth, 48, counter width in bits (33..64).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- core_events_i  in  NrCores*7  packed array of core_events_t; core c occupies bits [7c+6:7c]; bit 6 = issue_fpu … bit 0 = retired_acc.
- reg_req_i  in  1  register access request.
- reg_we_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  8  word address.
- reg_wdata_i  in  32  write data.
- reg_gnt_o  out  1  grant; combinationally equal to reg_req_i.
- reg_rvalid_o  out  1  response valid, exactly one cycle after each granted request (reads and writes).
- reg_rdata_o  out  32  read data; 0 for writes and errors.
- reg_err_o  out  1  qualifies rvalid; unmapped address.
- overflow_irq_o  out  1  OR of all sticky overflow bits.

Behaviour:
- Reset (rst_ni low at an edge):
  - All counters, configs, overflow bits and the event stage clear.
  - rvalid/rdata/err/overflow_irq = 0.
  - A request pending at reset is dropped; no response is issued.
- Event stage: core_events_i is registered once, with no gating.
- Counting:
  - Counter i increments by 1 on the edge after the staged bit is high, so there are 2 edges from strobe to count.
  - A read issued after that second edge returns the new value.
- Register map, per counter i, base 4i:
  - +0 CFG: bit0 enable; bits[3:1] evt_sel (0..6 = core_events_t bit index, 7 = clock cycles, core-independent); bits[15:8] core_sel; other bits read 0.
  - +1 VAL_LO: counter[31:0].
  - +2 VAL_HI: counter[CounterWidth-1:32], zero-extended.
  - +3 STATUS: bit0 sticky overflow; write 1 clears, write 0 has no effect.
- core_sel >= NrCores: the counter never counts, except when evt_sel=7. Reading CFG returns the written core_sel.
- Arithmetic:
  - Counter wraps modulo 2^CounterWidth.
  - On the wrap edge (all-ones plus increment) the counter becomes 0 and the overflow bit sets; overflow_irq_o rises in the same cycle the bit reads 1.
- Simultaneous events:
  - Write to VAL_LO/VAL_HI in the same cycle as an increment: the written value wins and the increment is lost. The other half is untouched.
  - Overflow set and W1C of STATUS in the same cycle: set wins.
  - Disabling a counter takes effect on the write edge; an increment staged for that edge is dropped.
- Addresses >= 4*NrCounters (except optional 0xFC): write ignored; response has err=1, rdata=0.
- Back-to-back requests every cycle are supported; each gets its own response one cycle later.

Optional Feature:
- Macro: SNITCH_PERF_FREEZE_EN.
- Defined:
  - Address 0xFC is the FREEZE register; bit0 = global freeze, reset 0, readable.
  - While frozen, no counter increments and no overflow is set. Register writes to VAL/CFG/STATUS still apply.
  - Freeze takes effect on the write edge, the same as disable.
- Not defined: 0xFC is unmapped and returns err=1; counters run whenever enabled.

Test Plan:
- Reset, then read CFG0 and VAL_LO0 -> rvalid one cycle after req; rdata=0, err=0; overflow_irq_o=0.
- CFG0 = enable, evt_sel=3 (retired_instr), core_sel=2; pulse core 2 bit 3 for 5 cycles and core 1 bit 3 for 5 cycles; wait 2 cycles -> VAL_LO0 = 5.
- Write VAL_HI0 = 0xFFFF and VAL_LO0 = 0xFFFFFFFE; count 3 cycles with evt_sel=7 -> VAL_LO0 = 1, VAL_HI0 = 0, STATUS0 = 1, overflow_irq_o = 1. Write STATUS0 = 1 -> irq falls one cycle later.
- Counter 1 counting cycles; write VAL_LO1 = 0x100 while it increments -> reads return 0x100 plus the cycles elapsed after the write edge, with no extra +1.
- Read address 0x40 with NrCounters=4 -> err=1, rdata=0. A write to 0x40 leaves all counters unchanged.
- With SNITCH_PERF_FREEZE_EN: counter running cycles, write 0xFC = 1, wait 10 cycles -> value unchanged; write 0xFC = 0 -> counting resumes. Without the macro, a read of 0xFC gives err=1.
